// File: rtl/pwm_capture_if.sv
// Signal bundle between a PWM source/monitor and pwm_capture.
// master drives the PWM input and observes the measurement; slave is the capture block.
interface pwm_capture_if #(
  parameter int CNT_W = 16
);
  logic             io_in;
  logic [CNT_W-1:0] io_period;
  logic [CNT_W-1:0] io_high;
  logic             io_valid;
  logic             io_stuck;
  logic             io_level;

  modport master (output io_in, input io_period, io_high, io_valid, io_stuck, io_level);
  modport slave  (input io_in, output io_period, io_high, io_valid, io_stuck, io_level);
endinterface

// File: rtl/pwm_capture.sv
// PWM period / high-time capture with stall detection.
// Optional glitch filter on the synced input: define PWM_CAPTURE_FILTER_EN.
module pwm_capture #(
  parameter int CNT_W    = 16,
  parameter int TIMEOUT  = 50000,
  parameter int FILT_LEN = 4
) (
  input logic          clock,
  input logic          reset,
  pwm_capture_if.slave pif
);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] TO      = CNT_W'(TIMEOUT);
  localparam logic [CNT_W-1:0] TO_M1   = CNT_W'(TIMEOUT - 1);

  if (TIMEOUT < 2 || FILT_LEN < 1) begin : g_bad_cfg
    $error("pwm_capture: TIMEOUT must be >= 2 and FILT_LEN >= 1");
  end

  typedef enum logic [1:0] {IDLE, HIGH, LOW} state_t;

  logic             sync1_q, sync2_q, prev_q, s;
  logic             rise, fall, edge_det;
  state_t           state_q, state_d;
  logic [CNT_W-1:0] per_q, per_d, hi_q, hi_d, idle_q, idle_d;
  logic [CNT_W-1:0] period_q, period_d, high_q, high_d;
  logic             valid_q, valid_d, stuck_q, stuck_d, level_q, level_d;

  function automatic logic [CNT_W-1:0] inc_sat(input logic [CNT_W-1:0] x);
    return (x == CNT_MAX) ? x : x + CNT_W'(1);
  endfunction

  always_ff @(posedge clock) begin
    if (!reset) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
    end else begin
      sync1_q <= pif.io_in;
      sync2_q <= sync1_q;
    end
  end

`ifdef PWM_CAPTURE_FILTER_EN
  localparam int FCW = (FILT_LEN > 1) ? $clog2(FILT_LEN) : 1;
  logic           filt_q;
  logic [FCW-1:0] fcnt_q;

  // fcnt_q counts how long the synced level has disagreed with filt_q
  always_ff @(posedge clock) begin
    if (!reset) begin
      filt_q <= 1'b0;
      fcnt_q <= '0;
    end else if (sync2_q == filt_q) begin
      fcnt_q <= '0;
    end else if (fcnt_q == FCW'(FILT_LEN - 1)) begin
      filt_q <= sync2_q;
      fcnt_q <= '0;
    end else begin
      fcnt_q <= fcnt_q + FCW'(1);
    end
  end
  assign s = filt_q;
`else
  assign s = sync2_q;
`endif

  assign rise     = s & ~prev_q;
  assign fall     = ~s & prev_q;
  assign edge_det = rise | fall;

  always_comb begin
    state_d  = state_q;
    per_d    = per_q;
    hi_d     = hi_q;
    period_d = period_q;
    high_d   = high_q;
    valid_d  = 1'b0;
    stuck_d  = stuck_q;
    level_d  = level_q;
    idle_d   = edge_det ? '0 : ((idle_q == TO) ? idle_q : idle_q + CNT_W'(1));
    if (edge_det) stuck_d = 1'b0;

    case (state_q)
      IDLE: begin
        if (rise) begin
          per_d   = CNT_W'(1);
          hi_d    = CNT_W'(1);
          state_d = HIGH;
        end
      end
      HIGH: begin
        per_d = inc_sat(per_q);
        if (fall) state_d = LOW;
        else      hi_d    = inc_sat(hi_q);
      end
      LOW: begin
        if (rise) begin
          period_d = per_q;
          high_d   = hi_q;
          valid_d  = 1'b1;
          per_d    = CNT_W'(1);
          hi_d     = CNT_W'(1);
          state_d  = HIGH;
        end else begin
          per_d = inc_sat(per_q);
        end
      end
      default: state_d = IDLE;
    endcase

    // idle_q saturates at TO, so the stall fires once per quiet stretch
    if (!edge_det && idle_q == TO_M1) begin
      stuck_d = 1'b1;
      level_d = s;
      state_d = IDLE;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      prev_q   <= 1'b0;
      state_q  <= IDLE;
      per_q    <= '0;
      hi_q     <= '0;
      idle_q   <= '0;
      period_q <= '0;
      high_q   <= '0;
      valid_q  <= 1'b0;
      stuck_q  <= 1'b0;
      level_q  <= 1'b0;
    end else begin
      prev_q   <= s;
      state_q  <= state_d;
      per_q    <= per_d;
      hi_q     <= hi_d;
      idle_q   <= idle_d;
      period_q <= period_d;
      high_q   <= high_d;
      valid_q  <= valid_d;
      stuck_q  <= stuck_d;
      level_q  <= level_d;
    end
  end

  assign pif.io_period = period_q;
  assign pif.io_high   = high_q;
  assign pif.io_valid  = valid_q & reset;
  assign pif.io_stuck  = stuck_q;
  assign pif.io_level  = level_q;
endmodule

// File: tb/tb_pwm_capture.sv
// Self-checking bench for pwm_capture: randomized PWM against an edge-timestamp model.
module tb_pwm_capture;
  localparam int CNT_W    = 8;
  localparam int TIMEOUT  = 250;
  localparam int FILT_LEN = 4;
  localparam int MAXV     = (1 << CNT_W) - 1;
`ifdef PWM_CAPTURE_FILTER_EN
  localparam int LAT  = 3 + FILT_LEN;
  localparam int MINW = FILT_LEN;
`else
  localparam int LAT  = 3;
  localparam int MINW = 1;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  pwm_capture_if #(.CNT_W(CNT_W)) pif ();
  pwm_capture #(.CNT_W(CNT_W), .TIMEOUT(TIMEOUT), .FILT_LEN(FILT_LEN)) dut (
    .clock(clk), .reset(rst_n), .pif(pif.slave)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { int per; int hi; int at; } meas_t;
  meas_t expq[$];
  int  n_chk = 0, n_pass = 0;
  bit  armed = 0;
  int  last_rise = 0, last_fall = 0, last_edge = 0;
  int  last_per = 0, last_hi = 0;
  bit  prev_valid = 0;

  function automatic int sat(input int x);
    return (x > MAXV) ? MAXV : x;
  endfunction

  // Model: a measurement is the time between consecutive input rises (and the
  // rise-to-fall time inside it), seen LAT cycles after the closing rise.
  task automatic set_in(input logic v, input bit log_it);
    meas_t m;
    if (log_it && v !== pif.io_in) begin
      if (cyc - last_edge > TIMEOUT) armed = 0;
      last_edge = cyc;
      if (v) begin
        if (armed) begin
          m.per = sat(cyc - last_rise);
          m.hi  = sat(last_fall - last_rise);
          m.at  = cyc + LAT;
          expq.push_back(m);
          last_per = m.per;
          last_hi  = m.hi;
        end
        armed     = 1;
        last_rise = cyc;
      end else begin
        last_fall = cyc;
      end
    end
    pif.io_in = v;
  endtask

  task automatic hold(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic drive_wave(input int h, input int l);
    set_in(1'b1, 1'b1); hold(h);
    set_in(1'b0, 1'b1); hold(l);
  endtask

  task automatic flush();
    set_in(1'b1, 1'b1);
    hold(LAT + 2);
    n_chk++;
    if (expq.size() != 0) $display("FAIL missing_valid: %0d expected measurements not seen, want 0", expq.size());
    else n_pass++;
    expq.delete();
  endtask

  // Reset clears the synchronizer, so an input still high afterwards looks
  // exactly like a fresh rise at the reset cycle.
  task automatic do_reset();
    int r;
    rst_n = 1'b0;
    hold(1);
    r = cyc;
    n_chk++;
    if ({pif.io_period, pif.io_high, pif.io_valid, pif.io_stuck, pif.io_level} !== '0)
      $display("FAIL reset_outputs: got per=%0d hi=%0d v=%b s=%b l=%b, want all 0",
               pif.io_period, pif.io_high, pif.io_valid, pif.io_stuck, pif.io_level);
    else n_pass++;
    rst_n = 1'b1;
    expq.delete();
    last_edge = r;
    last_per = 0;
    last_hi = 0;
    armed = (pif.io_in === 1'b1);
    last_rise = r;
  endtask

  always @(negedge clk) begin
    meas_t e;
    if (pif.io_valid === 1'b1) begin
      n_chk++;
      if (prev_valid) $display("FAIL valid_back_to_back: got valid at cyc %0d and %0d, want gap", cyc - 1, cyc);
      else if (expq.size() == 0)
        $display("FAIL spurious_valid: got per=%0d hi=%0d at cyc %0d, want no valid", pif.io_period, pif.io_high, cyc);
      else begin
        e = expq.pop_front();
        if (int'(pif.io_period) != e.per || int'(pif.io_high) != e.hi || cyc != e.at)
          $display("FAIL measurement: got per=%0d hi=%0d cyc=%0d, want per=%0d hi=%0d cyc=%0d",
                   pif.io_period, pif.io_high, cyc, e.per, e.hi, e.at);
        else n_pass++;
      end
    end
    prev_valid = (pif.io_valid === 1'b1);
  end

  task automatic test_reset();
    pif.io_in = 1'b0;
    hold(3);
    do_reset();
  endtask

  task automatic test_period_100();
    for (int i = 0; i < 5; i++) drive_wave(25, 75);
    flush();
    n_chk++;
    if (pif.io_stuck !== 1'b0) $display("FAIL p100_stuck: got %b, want 0", pif.io_stuck);
    else n_pass++;
  endtask

  task automatic test_period_2();
`ifndef PWM_CAPTURE_FILTER_EN
    for (int i = 0; i < 10; i++) drive_wave(1, 1);
    flush();
`endif
  endtask

  task automatic test_random();
    for (int i = 0; i < 8; i++)
      drive_wave($urandom_range(60, MINW), $urandom_range(60, MINW));
    flush();
  endtask

  task automatic test_glitch();
    drive_wave(30, 20);
`ifdef PWM_CAPTURE_FILTER_EN
    set_in(1'b1, 1'b0); hold(2);
    set_in(1'b0, 1'b0);
`else
    set_in(1'b1, 1'b1); hold(2);
    set_in(1'b0, 1'b1);
`endif
    hold(30);
    flush();
  endtask

  task automatic test_reset_mid();
    drive_wave(50, 50);
    drive_wave(50, 50);
    set_in(1'b1, 1'b1);
    hold(20);
    do_reset();
    hold(20);
    set_in(1'b0, 1'b1);
    hold(50);
    drive_wave(50, 50);
    drive_wave(50, 50);
    flush();
  endtask

  task automatic test_stuck();
    int c0, c1, tgt;
    c0  = last_edge;
    tgt = c0 + LAT + TIMEOUT;
    while (cyc < tgt - 1) @(negedge clk);
    n_chk++;
    if (pif.io_stuck !== 1'b0) $display("FAIL stuck_early: got %b at cyc %0d, want 0", pif.io_stuck, cyc);
    else n_pass++;
    hold(1);
    n_chk++;
    if (pif.io_stuck !== 1'b1 || pif.io_level !== 1'b1)
      $display("FAIL stuck_set: got stuck=%b level=%b, want 1 1", pif.io_stuck, pif.io_level);
    else n_pass++;
    n_chk++;
    if (int'(pif.io_period) != last_per || int'(pif.io_high) != last_hi)
      $display("FAIL stuck_keep: got per=%0d hi=%0d, want per=%0d hi=%0d", pif.io_period, pif.io_high, last_per, last_hi);
    else n_pass++;
    while (cyc < c0 + TIMEOUT + 10) @(negedge clk);
    set_in(1'b0, 1'b1);
    c1 = cyc;
    hold(LAT - 1);
    n_chk++;
    if (pif.io_stuck !== 1'b1) $display("FAIL stuck_hold: got %b at cyc %0d, want 1", pif.io_stuck, cyc);
    else n_pass++;
    hold(1);
    n_chk++;
    if (pif.io_stuck !== 1'b0) $display("FAIL stuck_clear: got %b at cyc %0d (edge at %0d), want 0", pif.io_stuck, cyc, c1);
    else n_pass++;
    for (int i = 0; i < 3; i++) drive_wave(40, 60);
    flush();
  endtask

  task automatic test_sat();
    for (int i = 0; i < 3; i++) drive_wave(180, 220);
    flush();
    n_chk++;
    if (int'(pif.io_period) != MAXV) $display("FAIL sat_period: got %0d, want %0d", pif.io_period, MAXV);
    else n_pass++;
  endtask

  initial begin
    test_reset();
    test_period_100();
    test_period_2();
    test_random();
    test_glitch();
    test_reset_mid();
    test_stuck();
    test_sat();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout at cyc %0d, want completion", cyc);
    $fatal(1, "watchdog");
  end
endmodule
